// File: rtl/de0_nano_cpu_cpu_debug_pkg.sv
// Shared definitions for the debug-monitor access path.
// Contents: the access state type, the jdo field positions and common widths.
package de0_nano_cpu_cpu_debug_pkg;

  localparam int unsigned JDO_W        = 38;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned LAT_W        = 2;   // holds RD_LAT-1 for RD_LAT in 1..3

  localparam int unsigned JDO_RD_BIT   = 35;  // read-after-load / clear-error qualifier
  localparam int unsigned JDO_LD_BIT   = 34;  // address-load qualifier
  localparam int unsigned JDO_DATA_LSB = 3;   // write data is jdo[34:3]
  localparam int unsigned JDO_ADDR_LSB = 17;  // word address starts at jdo[17]

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR
  } mon_state_e;

endpackage

// File: rtl/de0_nano_cpu_cpu_debug_mon_lat_cnt.sv
// Loadable down-counter that times the wait for monitor RAM read data.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   load_i        load load_val_i this cycle (takes precedence over counting)
//   load_val_i    value to load
//   done_c        combinational: counter has reached zero
module de0_nano_cpu_cpu_debug_mon_lat_cnt
  import de0_nano_cpu_cpu_debug_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic             done_c
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/de0_nano_cpu_cpu_debug_mon_access.sv
// Converts the debug slave's one-cycle JTAG commands into word reads and
// writes on the debug monitor RAM through an auto-incrementing address.
// Ports:
//   clk, reset_n             clock and asynchronous active-low reset
//   jdo                      JTAG data, valid while a take_* strobe is high
//   take_action_ocimem_a     address load / read-after-load / clear-error
//   take_no_action_ocimem_a  read the word at the current address
//   take_action_ocimem_b     write jdo[34:3] at the current address
//   ram_addr/ram_wdata       monitor RAM address and write data
//   ram_we/ram_re            one-cycle write / read enables
//   ram_rdata                RAM read data, valid RD_LAT cycles after ram_re
//   MonDReg                  last word read or written
//   monitor_ready            no access in flight
//   monitor_error            sticky: a command was dropped
module de0_nano_cpu_cpu_debug_mon_access
  import de0_nano_cpu_cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  mon_state_e        state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] mon_areg_q, mon_areg_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              ram_re_q, ram_re_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic idle_c;
  logic ld_c;
  logic rd_c;
  logic clr_c;
  logic drop_c;
  logic lat_load_c;
  logic lat_done_c;
  logic unused_jdo_c;

  // Bits of jdo that carry no meaning for this block.
  assign unused_jdo_c = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

  // A pending read-after-load counts as busy even though the state is IDLE.
  assign idle_c = (state_q == IDLE) && !rd_pend_q;
  assign ld_c   = jdo[JDO_LD_BIT];
  assign rd_c   = jdo[JDO_RD_BIT];
  assign clr_c  = take_action_ocimem_a && !ld_c && rd_c;

  // Commands that are dropped: priority losers when idle, everything but
  // the error-clear command when busy.
  assign drop_c = idle_c
    ? ((take_action_ocimem_a && (take_action_ocimem_b || take_no_action_ocimem_a)) ||
       (take_action_ocimem_b && take_no_action_ocimem_a))
    : (take_action_ocimem_b || take_no_action_ocimem_a ||
       (take_action_ocimem_a && !clr_c));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    mon_areg_d  = mon_areg_q;
    mon_dreg_d  = mon_dreg_q;
    err_d       = err_q;
    ram_re_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    lat_load_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_pend_q) begin
          // Read at the address loaded in the previous cycle.
          rd_pend_d  = 1'b0;
          state_d    = RD_ISSUE;
          ram_re_d   = 1'b1;
          ram_addr_d = mon_areg_q;
        end else if (take_action_ocimem_a) begin
          if (ld_c) begin
            mon_areg_d = jdo[JDO_ADDR_LSB +: ADDR_W];
            rd_pend_d  = rd_c;
          end
        end else if (take_action_ocimem_b) begin
          state_d     = WR;
          ram_we_d    = 1'b1;
          ram_addr_d  = mon_areg_q;
          ram_wdata_d = jdo[JDO_DATA_LSB +: DATA_W];
        end else if (take_no_action_ocimem_a) begin
          state_d    = RD_ISSUE;
          ram_re_d   = 1'b1;
          ram_addr_d = mon_areg_q;
        end
      end
      RD_ISSUE: begin
        lat_load_c = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_done_c) begin
          mon_dreg_d = ram_rdata;
          mon_areg_d = mon_areg_q + ADDR_W'(1);
          state_d    = IDLE;
        end
      end
      WR: begin
        mon_dreg_d = ram_wdata_q;
        mon_areg_d = mon_areg_q + ADDR_W'(1);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A dropped command in the same cycle as a clear leaves the flag set.
    if (clr_c) begin
      err_d = 1'b0;
    end
    if (drop_c) begin
      err_d = 1'b1;
    end
  end

  assign ready_d = (state_d == IDLE) && !rd_pend_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      mon_areg_q  <= '0;
      mon_dreg_q  <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      mon_areg_q  <= mon_areg_d;
      mon_dreg_q  <= mon_dreg_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Read data wait: loaded with RD_LAT-1 while the read is issued.
  de0_nano_cpu_cpu_debug_mon_lat_cnt u_lat_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (lat_load_c),
    .load_val_i (LAT_W'(RD_LAT - 1)),
    .done_c     (lat_done_c)
  );

  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign ram_re        = ram_re_q;
  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_de0_nano_cpu_cpu_debug_mon_access.sv
// Bench for the debug monitor access block: two instances (RD_LAT 1 and 3)
// share one directed stimulus; each has its own RAM and transaction model.
module tb_de0_nano_cpu_cpu_debug_mon_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta = 1'b0;
  logic        tb = 1'b0;
  logic        tn = 1'b0;

  logic [1:0][7:0]  ram_addr_w;
  logic [1:0][31:0] ram_wdata_w;
  logic [1:0][31:0] ram_rdata_w;
  logic [1:0][31:0] mondreg_w;
  logic [1:0]       ram_we_w;
  logic [1:0]       ram_re_w;
  logic [1:0]       ready_w;
  logic [1:0]       err_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic ld, input logic rd, input logic [7:0] addr);
    logic [37:0] d;
    d          = '0;
    d[37:36]   = 2'b11;       // ignored bits set to prove they are ignored
    d[16:3]    = 14'h1555;
    d[35]      = rd;
    d[34]      = ld;
    d[24:17]   = addr;
    return d;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] d;
    d        = '0;
    d[37:36] = 2'b10;
    d[2:0]   = 3'b101;
    d[34:3]  = data;
    return d;
  endfunction

  task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] d);
    @(negedge clk);
    ta = a; tb = b; tn = n; jdo = d;
    @(negedge clk);
    ta = 1'b0; tb = 1'b0; tn = 1'b0; jdo = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int unsigned LAT = (gi == 0) ? 1 : 3;

    de0_nano_cpu_cpu_debug_mon_access #(.ADDR_W(8), .RD_LAT(LAT)) dut (
      .clk                     (clk),
      .reset_n                 (rst_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (ta),
      .take_no_action_ocimem_a (tn),
      .take_action_ocimem_b    (tb),
      .ram_addr                (ram_addr_w[gi]),
      .ram_wdata               (ram_wdata_w[gi]),
      .ram_we                  (ram_we_w[gi]),
      .ram_re                  (ram_re_w[gi]),
      .ram_rdata               (ram_rdata_w[gi]),
      .MonDReg                 (mondreg_w[gi]),
      .monitor_ready           (ready_w[gi]),
      .monitor_error           (err_w[gi])
    );

    // Environment RAM with LAT-cycle read pipeline.
    logic [31:0] mem [256];
    logic [31:0] pipe [3];

    always @(posedge clk) begin
      pipe[0] <= mem[ram_addr_w[gi]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (ram_we_w[gi]) mem[ram_addr_w[gi]] = ram_wdata_w[gi];
    end
    assign ram_rdata_w[gi] = pipe[LAT-1];

    // Transaction model: an accepted command occupies the block for a fixed
    // number of edges and its effects land on the last one.
    int          m_busy = 0;
    logic        m_is_rd = 1'b0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_dreg = '0;
    logic [31:0] m_wd = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_mem [256];
    bit          was_busy;
    bit          clr;

    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]   = 32'h0A00_0000 | 32'(i);
        m_mem[i] = 32'h0A00_0000 | 32'(i);
      end
      mem[16]   = 32'hDEAD_BEEF;
      m_mem[16] = 32'hDEAD_BEEF;
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy = 0; m_is_rd = 1'b0; m_addr = '0; m_dreg = '0; m_wd = '0; m_err = 1'b0;
      end else begin
        was_busy = (m_busy > 0);
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            if (m_is_rd) begin
              m_dreg = m_mem[m_addr];
            end else begin
              m_dreg         = m_wd;
              m_mem[m_addr]  = m_wd;
            end
            m_addr = m_addr + 8'd1;
          end
        end
        clr = ta && !jdo[34] && jdo[35];
        if (was_busy) begin
          if (clr) m_err = 1'b0;
          if (tb || tn || (ta && !clr)) m_err = 1'b1;
        end else if (ta) begin
          if (clr) m_err = 1'b0;
          if (jdo[34]) begin
            m_addr = jdo[24:17];
            if (jdo[35]) begin
              m_is_rd = 1'b1;
              m_busy  = LAT + 2;
            end
          end
          if (tb || tn) m_err = 1'b1;
        end else if (tb) begin
          m_is_rd = 1'b0;
          m_wd    = jdo[34:3];
          m_busy  = 1;
          if (tn) m_err = 1'b1;
        end else if (tn) begin
          m_is_rd = 1'b1;
          m_busy  = LAT + 1;
        end
      end
    end

    // Per-cycle comparison of every output against the model.
    logic exp_re;
    logic exp_we;
    always @(negedge clk) begin
      exp_re = m_is_rd && (m_busy == LAT + 1);
      exp_we = !m_is_rd && (m_busy == 1);
      check($sformatf("L%0d MonDReg", LAT), mondreg_w[gi], m_dreg);
      check($sformatf("L%0d ready", LAT), 32'(ready_w[gi]), 32'(m_busy == 0));
      check($sformatf("L%0d error", LAT), 32'(err_w[gi]), 32'(m_err));
      check($sformatf("L%0d ram_re", LAT), 32'(ram_re_w[gi]), 32'(exp_re));
      check($sformatf("L%0d ram_we", LAT), 32'(ram_we_w[gi]), 32'(exp_we));
      if (exp_re || exp_we)
        check($sformatf("L%0d ram_addr", LAT), 32'(ram_addr_w[gi]), 32'(m_addr));
      if (exp_we)
        check($sformatf("L%0d ram_wdata", LAT), ram_wdata_w[gi], m_wd);
    end
  end

  initial begin
    // 1. reset, idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    for (int i = 0; i < 2; i++) begin
      check("T1 MonDReg", mondreg_w[i], 32'h0);
      check("T1 ready", 32'(ready_w[i]), 32'h1);
      check("T1 error", 32'(err_w[i]), 32'h0);
    end

    // 2. load 0x10 with read-after-load; L1 latency pinned by hand
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b1, 8'h10));
    idle(2);
    check("T2 L1 before update", mondreg_w[0], 32'h0);
    idle(1);
    check("T2 L1 at update", mondreg_w[0], 32'hDEAD_BEEF);
    idle(5);
    check("T2 L3 read", mondreg_w[1], 32'hDEAD_BEEF);

    // 3. writes wrapping 0xFE, 0xFF, 0x00
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'hFE));
    idle(1);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h1));
    idle(1);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h2));
    idle(1);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h3));
    idle(2);
    for (int i = 0; i < 2; i++) check("T3 MonDReg", mondreg_w[i], 32'h3);

    // 4. read, then a second read in the next cycle (dropped), then clear
    @(negedge clk);
    tn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tn = 1'b0;
    idle(8);
    for (int i = 0; i < 2; i++) begin
      check("T4 error set", 32'(err_w[i]), 32'h1);
      check("T4 MonDReg", mondreg_w[i], 32'h0A00_0001);
    end
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h00));
    idle(2);
    for (int i = 0; i < 2; i++) check("T4 error clr", 32'(err_w[i]), 32'h0);

    // 5. write and read strobes together: write wins
    pulse(1'b0, 1'b1, 1'b1, jdo_b(32'hCAFE_F00D));
    idle(3);
    for (int i = 0; i < 2; i++) begin
      check("T5 MonDReg", mondreg_w[i], 32'hCAFE_F00D);
      check("T5 error", 32'(err_w[i]), 32'h1);
    end

    // 6. reset during RD_WAIT, then read address 0
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h00));
    idle(1);
    pulse(1'b0, 1'b0, 1'b1, '0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("T6 async MonDReg", mondreg_w[i], 32'h0);
      check("T6 async ready", 32'(ready_w[i]), 32'h1);
      check("T6 async error", 32'(err_w[i]), 32'h0);
      check("T6 async ram_re", 32'(ram_re_w[i]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    pulse(1'b0, 1'b0, 1'b1, '0);
    idle(8);
    for (int i = 0; i < 2; i++) check("T6 read addr0", mondreg_w[i], 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
